// File: rtl/phase_decoder.sv
// Gate-drive read-back for one H-bridge motor channel: decodes the four observed
// drive lines into quadrature position, direction, drive period, activity and faults.

package phase_decoder_pkg;
    typedef logic [31:0] pfs_reg_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRACKING = 2'd2
    } state_t;
endpackage

module phase_decoder
    import phase_decoder_pkg::*;
#(
    parameter int SHORT_LIMIT = 16,
    parameter int TIMEOUT_US  = 1000
) (
    input  logic               clock_16mhz,
    input  logic               reset_n,
    input  logic               clock_1mhz,
    input  logic               ph_a_h,
    input  logic               ph_a_l,
    input  logic               ph_b_h,
    input  logic               ph_b_l,
    input  logic               clear,
    output logic signed [31:0] position,
    output logic               dir_obs,
    output pfs_reg_t           period_meas,
    output logic               period_valid,
    output logic               active,
    output logic               fault_short,
    output logic               fault_illegal,
    output logic [15:0]        err_count
);

    localparam int SHORT_W = $clog2(SHORT_LIMIT + 2);
    localparam int US_W    = $clog2(TIMEOUT_US + 1);
    localparam logic [SHORT_W-1:0] SHORT_MAX = SHORT_W'(SHORT_LIMIT);
    localparam logic [US_W-1:0]    US_LAST   = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]    US_MAX    = US_W'(TIMEOUT_US);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [3:0] raw_lines;
    logic [3:0] sync_1;
    logic [3:0] sync_2;

    assign raw_lines = {ph_b_l, ph_b_h, ph_a_l, ph_a_h};

    // NOTE: every clocked register uses <= so all flops see pre-edge values;
    // blocking assignments here would collapse the two stages into one.
    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw_lines;
            sync_2 <= sync_1;
        end
    end

    logic a_h_s, a_l_s, b_h_s, b_l_s;
    logic a_short, b_short;

    assign a_h_s   = sync_2[0];
    assign a_l_s   = sync_2[1];
    assign b_h_s   = sync_2[2];
    assign b_l_s   = sync_2[3];
    assign a_short = a_h_s & a_l_s;
    assign b_short = b_h_s & b_l_s;

    // ------------------------------------------------------------------
    // Level decoder: FLOAT and SHORT hold the last driven level
    // ------------------------------------------------------------------
    logic lvl_a, lvl_b;
    logic vld_a, vld_b;
    logic lvl_a_p, lvl_b_p;
    logic vld_p;

    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            lvl_a   <= 1'b0;
            lvl_b   <= 1'b0;
            vld_a   <= 1'b0;
            vld_b   <= 1'b0;
            lvl_a_p <= 1'b0;
            lvl_b_p <= 1'b0;
            vld_p   <= 1'b0;
        end else begin
            if (a_h_s ^ a_l_s) begin
                lvl_a <= a_h_s;
                vld_a <= 1'b1;
            end
            if (b_h_s ^ b_l_s) begin
                lvl_b <= b_h_s;
                vld_b <= 1'b1;
            end
            lvl_a_p <= lvl_a;
            lvl_b_p <= lvl_b;
            vld_p   <= vld_a & vld_b;
        end
    end

    // ------------------------------------------------------------------
    // Shoot-through run counters, saturating at SHORT_LIMIT
    // ------------------------------------------------------------------
    logic [SHORT_W-1:0] short_run_a;
    logic [SHORT_W-1:0] short_run_b;
    logic               short_trip;

    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            short_run_a <= '0;
            short_run_b <= '0;
        end else begin
            if (!a_short)
                short_run_a <= '0;
            else if (short_run_a != SHORT_MAX)
                short_run_a <= short_run_a + 1'b1;

            if (!b_short)
                short_run_b <= '0;
            else if (short_run_b != SHORT_MAX)
                short_run_b <= short_run_b + 1'b1;
        end
    end

    // The run counter holds the number of earlier SHORT samples in this run,
    // so the trip fires on the (SHORT_LIMIT+1)th one.
    assign short_trip = (a_short && short_run_a == SHORT_MAX) ||
                        (b_short && short_run_b == SHORT_MAX);

    // ------------------------------------------------------------------
    // Clear edge detect and 1us tick
    // ------------------------------------------------------------------
    logic clear_q, clear_d, clr_pulse;
    logic us_d;
    logic us_tick;

    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            clear_q   <= 1'b0;
            clear_d   <= 1'b0;
            clr_pulse <= 1'b0;
            us_d      <= 1'b0;
        end else begin
            clear_q   <= clear;
            clear_d   <= clear_q;
            clr_pulse <= clear_q & ~clear_d;
            us_d      <= clock_1mhz;
        end
    end

    assign us_tick = clock_1mhz & ~us_d;

    // ------------------------------------------------------------------
    // Quadrature edge classification (discarded while a clear is applied)
    // ------------------------------------------------------------------
    logic a_chg, b_chg;
    logic step_ev, illegal_ev, step_fwd, a_rise;

    assign a_chg      = vld_p & (lvl_a ^ lvl_a_p);
    assign b_chg      = vld_p & (lvl_b ^ lvl_b_p);
    assign step_ev    = (a_chg ^ b_chg) & ~clr_pulse;
    assign illegal_ev = a_chg & b_chg & ~clr_pulse;
    assign step_fwd   = a_chg ? (lvl_a != lvl_b) : (lvl_b == lvl_a);
    assign a_rise     = step_ev & a_chg & lvl_a;

    // ------------------------------------------------------------------
    // Inactivity timer in microseconds
    // ------------------------------------------------------------------
    logic [US_W-1:0] us_cnt;
    logic            timeout;

    assign timeout = us_tick && !step_ev && (us_cnt >= US_LAST);

    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n)
            us_cnt <= '0;
        else if (step_ev)
            us_cnt <= '0;
        else if (us_tick && us_cnt != US_MAX)
            us_cnt <= us_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Tracking FSM
    // ------------------------------------------------------------------
    state_t state, state_next;
    logic   per_load;
    logic   per_emit;

    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_next = state;
        per_load   = 1'b0;
        per_emit   = 1'b0;
        if (timeout) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (a_rise) begin
                        state_next = ST_ARMED;
                        per_load   = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (illegal_ev) begin
                        per_load = 1'b1;
                    end else if (a_rise) begin
                        state_next = ST_TRACKING;
                        per_load   = 1'b1;
                        per_emit   = 1'b1;
                    end
                end
                ST_TRACKING: begin
                    if (illegal_ev) begin
                        state_next = ST_ARMED;
                        per_load   = 1'b1;
                    end else if (a_rise) begin
                        per_load = 1'b1;
                        per_emit = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign active = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Period measurement
    // ------------------------------------------------------------------
    pfs_reg_t per_cnt;

    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt      <= '0;
            period_meas  <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= per_emit;
            if (per_emit)
                period_meas <= per_cnt;
            if (per_load)
                per_cnt <= 32'd1;
            else if (state != ST_IDLE && per_cnt != '1)
                per_cnt <= per_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Position, direction and fault bookkeeping; clear wins over an edge
    // ------------------------------------------------------------------
    always_ff @(posedge clock_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            position      <= '0;
            dir_obs       <= 1'b0;
            fault_short   <= 1'b0;
            fault_illegal <= 1'b0;
            err_count     <= '0;
        end else if (clr_pulse) begin
            position      <= '0;
            fault_short   <= 1'b0;
            fault_illegal <= 1'b0;
            err_count     <= '0;
        end else begin
            if (step_ev) begin
                position <= step_fwd ? position + 32'sd1 : position - 32'sd1;
                dir_obs  <= ~step_fwd;
            end
            if (illegal_ev) begin
                fault_illegal <= 1'b1;
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
            if (short_trip)
                fault_short <= 1'b1;
        end
    end

endmodule
